branch_resolve_ctrl: RTL and testbench

Sequencing controller for the decode-stage branch condition checker. Holds a branch in decode until its operands are ready and drives the branch command to the checker. On a taken result it issues a one-cycle PC redirect and IF/ID flush. It also keeps saturating taken/not-taken statistics and a sticky operand-wait timeout flag.

---
 rtl/branch_resolve_ctrl.sv | 156 +++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_ctrl
//  Description : Decode-stage branch sequencing controller. Holds a branch in
//                decode until its operands are ready, forwards the branch
//                command to the condition checker, and turns a taken result
//                into a one-cycle PC redirect plus IF/ID flush. Keeps
//                saturating taken/not-taken statistics and a sticky
//                operand-wait timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_ctrl #(
    parameter int WAIT_MAX = 15,
    parameter int WAIT_W   = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             idBranchValid,
    input  logic [1:0]       idBranchCmd,
    input  logic [31:0]      idTarget,
    input  logic             opReady,
    input  logic             stallIn,
    input  logic             brCond,
    input  logic             errClr,
    output logic [1:0]       cuBranchComm,
    output logic             pcLoad,
    output logic [31:0]      pcTarget,
    output logic             flushIfId,
    output logic             stallDecode,
    output logic [CNT_W-1:0] takenCnt,
    output logic [CNT_W-1:0] notTakenCnt,
    output logic             hazardErr
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO  = '0;
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT     = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;

    // ------------------------------------------------------------------------
    // Cycle classification
    // ------------------------------------------------------------------------
    logic              in_decode;     // a branch in decode may be evaluated
    logic              op_wait;       // branch present but operands missing
    logic [WAIT_W-1:0] wait_next;     // saturating next wait count
    logic              timeout;       // wait count lands on the limit
    logic              taken_full;
    logic              not_taken_full;

    assign in_decode      = (state == ST_IDLE) || (state == ST_WAIT);
    assign op_wait        = in_decode && idBranchValid && !opReady && !stallIn;
    assign wait_next      = (wait_cnt >= WAIT_LIMIT) ? WAIT_LIMIT
                                                     : (wait_cnt + WAIT_ONE);
    assign timeout        = op_wait && (wait_next == WAIT_LIMIT);
    assign taken_full     = &takenCnt;
    assign not_taken_full = &notTakenCnt;

    // ------------------------------------------------------------------------
    // Combinational outputs
    // ------------------------------------------------------------------------
    // The checker sees the decode command directly so brCond settles in the
    // same cycle as the next-state decision.
    assign cuBranchComm = idBranchCmd;

    // Redirect and flush fire only from REDIRECT and are suppressed while the
    // pipeline is frozen, which stretches the redirect until the freeze ends.
    assign pcLoad    = (state == ST_REDIRECT) && !stallIn;
    assign flushIfId = (state == ST_REDIRECT) && !stallIn;

    // The reset term keeps the decode stall quiet while reset is held, since
    // the raw inputs can still describe a waiting branch at that time.
    assign stallDecode = op_wait && rstN;

    // Branch sequencing FSM with its wait counter, redirect address,
    // statistics and sticky timeout flag.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state       <= ST_IDLE;
            wait_cnt    <= WAIT_ZERO;
            pcTarget    <= 32'h0000_0000;
            takenCnt    <= '0;
            notTakenCnt <= '0;
            hazardErr   <= 1'b0;
        end else begin
            // A global freeze holds every piece of sequencing state.
            if (!stallIn) begin
                case (state)
                    ST_IDLE, ST_WAIT: begin
                        if (idBranchValid) begin
                            if (opReady) begin
                                // Resolve: the checker result decides the path.
                                wait_cnt <= WAIT_ZERO;
                                if (brCond) begin
                                    pcTarget <= idTarget;
                                    state    <= ST_REDIRECT;
                                    if (!taken_full) begin
                                        takenCnt <= takenCnt + CNT_ONE;
                                    end
                                end else begin
                                    state <= ST_IDLE;
                                    if (!not_taken_full) begin
                                        notTakenCnt <= notTakenCnt + CNT_ONE;
                                    end
                                end
                            end else begin
                                // Operands outstanding: keep the branch parked.
                                state    <= ST_WAIT;
                                wait_cnt <= wait_next;
                            end
                        end else begin
                            // Nothing in decode, or the waiting branch was
                            // squashed upstream.
                            state    <= ST_IDLE;
                            wait_cnt <= WAIT_ZERO;
                        end
                    end
                    ST_REDIRECT: begin
                        // Decode holds a wrong-path instruction that is being
                        // flushed, so its valid bit is not looked at here.
                        state <= ST_IDLE;
                    end
                    default: begin
                        state    <= ST_IDLE;
                        wait_cnt <= WAIT_ZERO;
                    end
                endcase
            end

            // A timeout in the same cycle as a clear keeps the flag set.
            if (timeout) begin
                hazardErr <= 1'b1;
            end else if (errClr) begin
                hazardErr <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolve_ctrl
//  Description : Directed self-checking bench for branch_resolve_ctrl. Two
//                instances share the stimulus: one with default parameters
//                and one with WAIT_MAX=4 and 4-bit counters for the timeout
//                and saturation behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_ctrl;

    logic        clk;
    logic        rstN;
    logic        idBranchValid;
    logic [1:0]  idBranchCmd;
    logic [31:0] idTarget;
    logic        opReady;
    logic        stallIn;
    logic        brCond;
    logic        errClr;

    logic [1:0]  cuBranchComm;
    logic        pcLoad;
    logic [31:0] pcTarget;
    logic        flushIfId;
    logic        stallDecode;
    logic [15:0] takenCnt;
    logic [15:0] notTakenCnt;
    logic        hazardErr;

    logic [1:0]  s_cuBranchComm;
    logic        s_pcLoad;
    logic [31:0] s_pcTarget;
    logic        s_flushIfId;
    logic        s_stallDecode;
    logic [3:0]  s_takenCnt;
    logic [3:0]  s_notTakenCnt;
    logic        s_hazardErr;

    branch_resolve_ctrl dut (
        .clk          (clk),
        .rstN         (rstN),
        .idBranchValid(idBranchValid),
        .idBranchCmd  (idBranchCmd),
        .idTarget     (idTarget),
        .opReady      (opReady),
        .stallIn      (stallIn),
        .brCond       (brCond),
        .errClr       (errClr),
        .cuBranchComm (cuBranchComm),
        .pcLoad       (pcLoad),
        .pcTarget     (pcTarget),
        .flushIfId    (flushIfId),
        .stallDecode  (stallDecode),
        .takenCnt     (takenCnt),
        .notTakenCnt  (notTakenCnt),
        .hazardErr    (hazardErr)
    );

    branch_resolve_ctrl #(
        .WAIT_MAX(4),
        .WAIT_W  (3),
        .CNT_W   (4)
    ) dut_s (
        .clk          (clk),
        .rstN         (rstN),
        .idBranchValid(idBranchValid),
        .idBranchCmd  (idBranchCmd),
        .idTarget     (idTarget),
        .opReady      (opReady),
        .stallIn      (stallIn),
        .brCond       (brCond),
        .errClr       (errClr),
        .cuBranchComm (s_cuBranchComm),
        .pcLoad       (s_pcLoad),
        .pcTarget     (s_pcTarget),
        .flushIfId    (s_flushIfId),
        .stallDecode  (s_stallDecode),
        .takenCnt     (s_takenCnt),
        .notTakenCnt  (s_notTakenCnt),
        .hazardErr    (s_hazardErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected observation for one cycle
    typedef struct {
        logic [1:0]  cmd;
        logic        pl;
        logic        fl;
        logic        sd;
        logic [31:0] pct;
        logic [15:0] tk;
        logic [15:0] nt;
        logic        haz;
        logic [3:0]  tk_s;
        logic [3:0]  nt_s;
        logic        haz_s;
    } exp_t;

    exp_t q[$];

    int total = 0;
    int bad   = 0;

    // Registered state the bench expects to be visible in the current cycle
    logic [31:0] e_pct;
    int          e_tk;
    int          e_nt;
    logic        e_haz;
    logic        e_haz_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected outputs, advance a clock
    task automatic step(input logic v, input logic [1:0] cmd, input logic [31:0] tgt,
                        input logic opr, input logic stl, input logic cond, input logic clr,
                        input logic pl, input logic fl, input logic sd);
        exp_t e;
        idBranchValid = v;
        idBranchCmd   = cmd;
        idTarget      = tgt;
        opReady       = opr;
        stallIn       = stl;
        brCond        = cond;
        errClr        = clr;
        e.cmd   = cmd;
        e.pl    = pl;
        e.fl    = fl;
        e.sd    = sd;
        e.pct   = e_pct;
        e.tk    = (e_tk > 65535) ? 16'hFFFF : 16'(e_tk);
        e.nt    = (e_nt > 65535) ? 16'hFFFF : 16'(e_nt);
        e.haz   = e_haz;
        e.tk_s  = (e_tk > 15) ? 4'hF : 4'(e_tk);
        e.nt_s  = (e_nt > 15) ? 4'hF : 4'(e_nt);
        e.haz_s = e_haz_s;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Compare the oldest queued expectation against both instances mid-cycle
    always @(negedge clk) begin : b_check
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("cuBranchComm", 32'(cuBranchComm), 32'(e.cmd));
            chk("pcLoad",       32'(pcLoad),       32'(e.pl));
            chk("flushIfId",    32'(flushIfId),    32'(e.fl));
            chk("stallDecode",  32'(stallDecode),  32'(e.sd));
            chk("pcTarget",     pcTarget,          e.pct);
            chk("takenCnt",     32'(takenCnt),     32'(e.tk));
            chk("notTakenCnt",  32'(notTakenCnt),  32'(e.nt));
            chk("hazardErr",    32'(hazardErr),    32'(e.haz));
            chk("s_cuBranchComm", 32'(s_cuBranchComm), 32'(e.cmd));
            chk("s_pcLoad",     32'(s_pcLoad),     32'(e.pl));
            chk("s_flushIfId",  32'(s_flushIfId),  32'(e.fl));
            chk("s_stallDecode", 32'(s_stallDecode), 32'(e.sd));
            chk("s_pcTarget",   s_pcTarget,        e.pct);
            chk("s_takenCnt",   32'(s_takenCnt),   32'(e.tk_s));
            chk("s_notTakenCnt", 32'(s_notTakenCnt), 32'(e.nt_s));
            chk("s_hazardErr",  32'(s_hazardErr),  32'(e.haz_s));
        end
    end

    initial begin
        rstN          = 1'b0;
        idBranchValid = 1'b0;
        idBranchCmd   = 2'd0;
        idTarget      = 32'h0;
        opReady       = 1'b0;
        stallIn       = 1'b0;
        brCond        = 1'b0;
        errClr        = 1'b0;
        e_pct   = 32'h0;
        e_tk    = 0;
        e_nt    = 0;
        e_haz   = 1'b0;
        e_haz_s = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        step(0, 2'd0, 32'h0, 0, 0, 0, 0,   0, 0, 0);
        rstN = 1'b1;
        step(0, 2'd0, 32'h0, 0, 0, 0, 0,   0, 0, 0);

        // JUMP taken to 0x400; the wrong-path valid in REDIRECT is ignored
        step(1, 2'd0, 32'h0000_0400, 1, 0, 1, 0,   0, 0, 0);
        e_pct = 32'h0000_0400; e_tk = 1;
        step(1, 2'd1, 32'h0000_0DEAD, 0, 0, 0, 0,   1, 1, 0);
        step(0, 2'd0, 32'h0, 0, 0, 0, 0,   0, 0, 0);

        // BEZ not taken: no redirect, no bubble
        step(1, 2'd1, 32'h0000_0800, 1, 0, 0, 0,   0, 0, 0);
        e_nt = 1;
        step(0, 2'd0, 32'h0, 0, 0, 0, 0,   0, 0, 0);

        // BNE waits 3 cycles for operands, then taken
        for (int i = 0; i < 3; i++) begin
            step(1, 2'd2, 32'h0000_1000, 0, 0, 0, 0,   0, 0, 1);
        end
        step(1, 2'd2, 32'h0000_1000, 1, 0, 1, 0,   0, 0, 0);
        e_pct = 32'h0000_1000; e_tk = 2;
        step(0, 2'd0, 32'h0, 0, 0, 0, 0,   1, 1, 0);

        // Back-to-back: a branch resolves in the cycle right after REDIRECT
        step(1, 2'd1, 32'h0000_1100, 1, 0, 0, 0,   0, 0, 0);
        e_nt = 2;

        // Operand wait of 6 cycles: WAIT_MAX=4 instance times out after the 4th
        for (int i = 0; i < 6; i++) begin
            step(1, 2'd1, 32'h0000_1200, 0, 0, 0, 0,   0, 0, 1);
            if (i == 3) e_haz_s = 1'b1;
        end
        // Withdraw the waiting branch, then clear the sticky flag
        step(0, 2'd0, 32'h0, 0, 0, 0, 0,   0, 0, 0);
        step(0, 2'd0, 32'h0, 0, 0, 0, 1,   0, 0, 0);
        e_haz_s = 1'b0;
        // Timeout coinciding with errClr: the set wins
        for (int i = 0; i < 3; i++) begin
            step(1, 2'd2, 32'h0000_1300, 0, 0, 0, 0,   0, 0, 1);
        end
        step(1, 2'd2, 32'h0000_1300, 0, 0, 0, 1,   0, 0, 1);
        e_haz_s = 1'b1;
        step(0, 2'd0, 32'h0, 0, 0, 0, 0,   0, 0, 0);

        // Freeze in IDLE: neither resolve nor stall decode
        step(1, 2'd0, 32'h0000_5000, 1, 1, 1, 0,   0, 0, 0);
        step(1, 2'd0, 32'h0000_5000, 0, 1, 0, 0,   0, 0, 0);

        // Taken branch whose redirect is held off by 2 frozen cycles
        step(1, 2'd0, 32'h0000_2000, 1, 0, 1, 0,   0, 0, 0);
        e_pct = 32'h0000_2000; e_tk = 3;
        step(0, 2'd0, 32'h0, 0, 1, 0, 0,   0, 0, 0);
        step(0, 2'd0, 32'h0, 0, 1, 0, 0,   0, 0, 0);
        step(0, 2'd0, 32'h0, 0, 0, 0, 0,   1, 1, 0);
        step(0, 2'd0, 32'h0, 0, 0, 0, 0,   0, 0, 0);

        // Illegal command resolves as not taken
        step(1, 2'd3, 32'h0000_3000, 1, 0, 0, 0,   0, 0, 0);
        e_nt = 3;

        // Saturation: small instance's 4-bit taken counter sticks at 0xF
        for (int i = 0; i < 16; i++) begin
            step(1, 2'd0, 32'(i + 1) << 8, 1, 0, 1, 0,   0, 0, 0);
            e_pct = 32'(i + 1) << 8;
            e_tk  = e_tk + 1;
            step(0, 2'd0, 32'h0, 0, 0, 0, 0,   1, 1, 0);
        end

        // Asynchronous reset in the middle of an operand wait
        step(1, 2'd2, 32'h0000_6000, 0, 0, 0, 0,   0, 0, 1);
        rstN    = 1'b0;
        e_pct   = 32'h0;
        e_tk    = 0;
        e_nt    = 0;
        e_haz   = 1'b0;
        e_haz_s = 1'b0;
        step(1, 2'd2, 32'h0000_6000, 0, 0, 0, 0,   0, 0, 0);
        rstN = 1'b1;
        step(0, 2'd0, 32'h0, 0, 0, 0, 0,   0, 0, 0);
        step(1, 2'd1, 32'h0000_7000, 1, 0, 0, 0,   0, 0, 0);
        e_nt = 1;
        step(0, 2'd0, 32'h0, 0, 0, 0, 0,   0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
